// File: rtl/l2_arb_pkg.sv
// Shared types for the two-port L2 arbiter: FSM states, port ids and the L2 request bundle.
package l2_arb_pkg;

    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // 0 = instruction cache, 1 = data cache
    typedef logic port_id_t;

    typedef struct packed {
        logic                     write_enable;
        logic [L2_ADDR_WIDTH-1:0] address;
        logic [L2_DATA_WIDTH-1:0] write_data;
    } l2_req_t;

endpackage

// File: rtl/l2_arb_timer.sv
// Saturating BUSY-cycle counter for the arbiter watchdog; TIMEOUT_CYCLES = 0 never expires.
module l2_arb_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LIMIT   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST    = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic          ENABLED = (TIMEOUT_CYCLES > 0);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Expires on the last allowed BUSY cycle so the abort lands after exactly TIMEOUT_CYCLES.
    assign expired = ENABLED && (count == LAST);

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache (port 0) and D-cache (port 1).
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH     = L2_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_request,
    input  logic                  p1_request,
    input  logic                  p0_write_enable,
    input  logic                  p1_write_enable,
    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0] p0_write_data,
    input  logic [DATA_WIDTH-1:0] p1_write_data,
    output logic [DATA_WIDTH-1:0] p0_response_data,
    output logic [DATA_WIDTH-1:0] p1_response_data,
    output logic                  p0_ready,
    output logic                  p1_ready,
    output logic                  p0_error,
    output logic                  p1_error,
    output logic                  l2_request,
    output logic                  l2_write_enable,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [DATA_WIDTH-1:0] l2_write_data,
    input  logic [DATA_WIDTH-1:0] l2_response_data,
    input  logic                  l2_ready,
    output logic                  grant_owner,
    output logic [1:0]            a_state
);

    // Handshake: a port holds request (with stable address/data) until its one-cycle ready
    // pulse; l2_request stays high with stable fields until l2_ready or the watchdog fires.

    typedef struct packed {
        logic                  write_enable;
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] write_data;
    } port_req_t;

    arb_state_t                  state, state_n;
    port_id_t                    last_served, last_served_n;
    port_id_t                    owner_q, owner_n;
    port_id_t                    winner;
    port_req_t                   l2_q, l2_n;
    logic                        l2_request_q, l2_request_n;
    logic [1:0][DATA_WIDTH-1:0]  rdata_q, rdata_n;
    logic [1:0]                  ready_q, ready_n;
    logic [1:0]                  error_q, error_n;
    port_req_t [1:0]             req_in;
    logic [1:0]                  req_vld;
    logic                        timer_clear;
    logic                        timer_enable;
    logic                        timer_expired;

    assign req_in[0] = {p0_write_enable, p0_address, p0_write_data};
    assign req_in[1] = {p1_write_enable, p1_address, p1_write_data};
    assign req_vld   = {p1_request, p0_request};

    assign timer_enable = (state == BUSY);

    l2_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_n       = state;
        last_served_n = last_served;
        owner_n       = owner_q;
        winner        = last_served;
        l2_n          = l2_q;
        l2_request_n  = l2_request_q;
        rdata_n       = rdata_q;
        ready_n       = ready_q;
        error_n       = error_q;
        timer_clear   = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_vld != 2'b00) begin
                    // On a tie the port that was not served last wins.
                    if (req_vld == 2'b11) begin
                        winner = ~last_served;
                    end else begin
                        winner = req_vld[1];
                    end
                    l2_n          = req_in[winner];
                    l2_request_n  = 1'b1;
                    owner_n       = winner;
                    last_served_n = winner;
                    timer_clear   = 1'b1;
                    state_n       = BUSY;
                end
            end
            BUSY: begin
                if (l2_ready) begin
                    rdata_n[owner_q] = l2_response_data;
                    ready_n[owner_q] = 1'b1;
                    l2_request_n     = 1'b0;
                    state_n          = RESP;
                end else if (timer_expired) begin
                    rdata_n[owner_q] = '0;
                    ready_n[owner_q] = 1'b1;
                    error_n[owner_q] = 1'b1;
                    l2_request_n     = 1'b0;
                    state_n          = RESP;
                end
            end
            RESP: begin
                // One dead cycle lets the requester drop its request before IDLE samples it.
                rdata_n = '0;
                ready_n = '0;
                error_n = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_served  <= 1'b1;
            owner_q      <= 1'b0;
            l2_q         <= '0;
            l2_request_q <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= '0;
            error_q      <= '0;
        end else begin
            state        <= state_n;
            last_served  <= last_served_n;
            owner_q      <= owner_n;
            l2_q         <= l2_n;
            l2_request_q <= l2_request_n;
            rdata_q      <= rdata_n;
            ready_q      <= ready_n;
            error_q      <= error_n;
        end
    end

    assign l2_request       = l2_request_q;
    assign l2_write_enable  = l2_q.write_enable;
    assign l2_address       = l2_q.address;
    assign l2_write_data    = l2_q.write_data;
    assign p0_response_data = rdata_q[0];
    assign p1_response_data = rdata_q[1];
    assign p0_ready         = ready_q[0];
    assign p1_ready         = ready_q[1];
    assign p0_error         = error_q[0];
    assign p1_error         = error_q[1];
    assign grant_owner      = owner_q;
    assign a_state          = state;

endmodule
